// File: rtl/hdmi_word_align.sv
// hdmi_word_align
// Finds the 10-bit word boundary in a raw TMDS deserializer stream by hunting
// for runs of control tokens at each of the 10 possible bit rotations, then
// emits boundary-aligned words with control-token decode and lock status.
// One instance per TMDS channel, pixel clock domain.
//
// Ports:
//   i_clk        pixel clock
//   i_reset_n    synchronous active-low reset
//   i_ce         i_word valid this cycle
//   i_word       raw deserialized word, bit 0 received first
//   i_realign    one-cycle request to drop the current rotation and search again
//   o_ce         output word valid (one cycle after i_ce)
//   o_word       aligned TMDS word
//   o_ctrl       o_word is a control token
//   o_ctrl_data  decoded {C1,C0} of the control token, 00 otherwise
//   o_locked     word boundary established
//   o_shift      current rotation, 0..9
//
// state  | meaning
// SEARCH | dwell at each rotation looking for MIN_RUN consecutive tokens
// LOCKED | rotation frozen; drop lock if no qualifying run within the timeout
module hdmi_word_align #(
    parameter int MIN_RUN   = 8,
    parameter int LGDWELL   = 12,
    parameter int LGTIMEOUT = 22
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_ce,
    input  logic [9:0] i_word,
    input  logic       i_realign,
    output logic       o_ce,
    output logic [9:0] o_word,
    output logic       o_ctrl,
    output logic [1:0] o_ctrl_data,
    output logic       o_locked,
    output logic [3:0] o_shift
);
    localparam int RUN_W = $clog2(MIN_RUN + 1);
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(MIN_RUN);

    typedef enum logic {
        SEARCH = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t               state, state_nx;
    logic [3:0]           shift, shift_nx;
    logic [RUN_W-1:0]     run, run_upd, run_nx;
    logic [LGDWELL-1:0]   dwell, dwell_nx;
    logic [LGTIMEOUT-1:0] tmo, tmo_nx;
    logic [9:0]           prev;
    logic [9:0]           candidate;
    logic                 match;
    logic [1:0]           dec;
    logic                 hit;
    logic                 adv;

    // prev holds the older bits, so rotation s takes bits s..s+9 of {i_word,prev}.
    assign candidate = 10'({i_word, prev} >> shift);

    always_comb begin
        match = 1'b1;
        dec   = 2'b00;
        case (candidate)
            10'h354: dec = 2'b00;
            10'h0AB: dec = 2'b01;
            10'h154: dec = 2'b10;
            10'h2AB: dec = 2'b11;
            default: match = 1'b0;
        endcase
    end

    always_comb begin
        run_upd = run;
        if (i_ce) begin
            if (!match)
                run_upd = '0;
            else if (run != RUN_MAX)
                run_upd = run + 1'b1;
        end
    end

    // A saturated run keeps qualifying on every further token.
    assign hit = i_ce && match && (run_upd == RUN_MAX);

    always_comb begin
        state_nx = state;
        shift_nx = shift;
        run_nx   = run_upd;
        dwell_nx = dwell;
        tmo_nx   = tmo;
        adv      = 1'b0;
        if (i_realign) begin
            state_nx = SEARCH;
            adv      = 1'b1;
            run_nx   = '0;
            dwell_nx = '0;
            tmo_nx   = '0;
        end else begin
            case (state)
                SEARCH: begin
                    if (i_ce)
                        dwell_nx = dwell + 1'b1;
                    if (hit) begin
                        state_nx = LOCKED;
                        dwell_nx = '0;
                        tmo_nx   = '0;
                    end else if (i_ce && (&dwell)) begin
                        adv      = 1'b1;
                        run_nx   = '0;
                        dwell_nx = '0;
                    end
                end
                LOCKED: begin
                    if (i_ce)
                        tmo_nx = tmo + 1'b1;
                    if (hit) begin
                        tmo_nx = '0;
                    end else if (i_ce && (&tmo)) begin
                        state_nx = SEARCH;
                        adv      = 1'b1;
                        run_nx   = '0;
                        dwell_nx = '0;
                        tmo_nx   = '0;
                    end
                end
                default: state_nx = SEARCH;
            endcase
        end
        if (adv)
            shift_nx = (shift == 4'd9) ? 4'd0 : shift + 4'd1;
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state <= SEARCH;
            shift <= '0;
            run   <= '0;
            dwell <= '0;
            tmo   <= '0;
        end else begin
            state <= state_nx;
            shift <= shift_nx;
            run   <= run_nx;
            dwell <= dwell_nx;
            tmo   <= tmo_nx;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            prev        <= '0;
            o_ce        <= 1'b0;
            o_word      <= '0;
            o_ctrl      <= 1'b0;
            o_ctrl_data <= 2'b00;
        end else begin
            o_ce <= i_ce;
            if (i_ce) begin
                prev        <= i_word;
                o_word      <= candidate;
                o_ctrl      <= match;
                o_ctrl_data <= dec;
            end
        end
    end

    assign o_locked = (state == LOCKED);
    assign o_shift  = shift;

endmodule

// File: tb/tb_hdmi_word_align.sv
// Testbench for hdmi_word_align: directed sequences with random filler data,
// every output compared each cycle against a bit-stream reference model.
module tb_hdmi_word_align;
    localparam int MIN_RUN   = 8;
    localparam int LGDWELL   = 4;
    localparam int LGTIMEOUT = 6;
    localparam int DWELL     = 1 << LGDWELL;
    localparam int TMO       = 1 << LGTIMEOUT;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_ce = 1'b0;
    logic [9:0] i_word = '0;
    logic       i_realign = 1'b0;
    logic       o_ce;
    logic [9:0] o_word;
    logic       o_ctrl;
    logic [1:0] o_ctrl_data;
    logic       o_locked;
    logic [3:0] o_shift;

    int total = 0;
    int bad   = 0;

    hdmi_word_align #(
        .MIN_RUN  (MIN_RUN),
        .LGDWELL  (LGDWELL),
        .LGTIMEOUT(LGTIMEOUT)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_ce       (i_ce),
        .i_word     (i_word),
        .i_realign  (i_realign),
        .o_ce       (o_ce),
        .o_word     (o_word),
        .o_ctrl     (o_ctrl),
        .o_ctrl_data(o_ctrl_data),
        .o_locked   (o_locked),
        .o_shift    (o_shift)
    );

    always #5 i_clk = ~i_clk;

    // reference model: the received bit stream plus plain integer counters
    bit         hist[$];
    int         m_shift, m_run, m_dwell, m_tmo;
    bit         m_locked;
    bit         e_ce, e_ctrl;
    logic [9:0] e_word;
    logic [1:0] e_data;

    function automatic int tok_code(input logic [9:0] w);
        case (w)
            10'h354: return 0;
            10'h0AB: return 1;
            10'h154: return 2;
            10'h2AB: return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < 10; i++) hist.push_back(1'b0);
        m_shift = 0; m_run = 0; m_dwell = 0; m_tmo = 0; m_locked = 0;
        e_ce = 0; e_ctrl = 0; e_word = '0; e_data = '0;
    endtask

    task automatic model_step(input bit ce, input logic [9:0] w, input bit rl);
        logic [9:0] cand;
        int code;
        bit hit;
        hit  = 0;
        e_ce = ce;
        if (ce) begin
            for (int i = 0; i < 10; i++) hist.push_back(w[i]);
            for (int j = 0; j < 10; j++) cand[j] = hist[m_shift + j];
            for (int i = 0; i < 10; i++) void'(hist.pop_front());
            code   = tok_code(cand);
            e_word = cand;
            e_ctrl = (code >= 0);
            e_data = (code >= 0) ? 2'(code) : 2'b00;
            m_run  = (code >= 0) ? ((m_run < MIN_RUN) ? m_run + 1 : MIN_RUN) : 0;
            hit    = (code >= 0) && (m_run == MIN_RUN);
        end
        if (rl) begin
            m_shift = (m_shift + 1) % 10;
            m_locked = 0; m_run = 0; m_dwell = 0; m_tmo = 0;
        end else if (!m_locked) begin
            if (ce) m_dwell++;
            if (hit) begin
                m_locked = 1; m_dwell = 0; m_tmo = 0;
            end else if (m_dwell == DWELL) begin
                m_shift = (m_shift + 1) % 10; m_run = 0; m_dwell = 0;
            end
        end else begin
            if (ce) m_tmo++;
            if (hit) m_tmo = 0;
            else if (m_tmo == TMO) begin
                m_shift = (m_shift + 1) % 10;
                m_locked = 0; m_run = 0; m_dwell = 0; m_tmo = 0;
            end
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("o_ce", 32'(o_ce), 32'(e_ce));
        chk("o_word", 32'(o_word), 32'(e_word));
        chk("o_ctrl", 32'(o_ctrl), 32'(e_ctrl));
        chk("o_ctrl_data", 32'(o_ctrl_data), 32'(e_data));
        chk("o_locked", 32'(o_locked), 32'(m_locked));
        chk("o_shift", 32'(o_shift), 32'(m_shift));
    endtask

    task automatic cyc(input bit ce, input logic [9:0] w, input bit rl);
        i_ce = ce; i_word = w; i_realign = rl;
        model_step(ce, w, rl);
        @(posedge i_clk);
        #1;
        check_all();
        i_realign = 1'b0;
    endtask

    task automatic do_reset();
        i_reset_n = 1'b0; i_ce = 1'b1; i_word = 10'($urandom); i_realign = 1'b0;
        model_reset();
        @(posedge i_clk);
        #1;
        check_all();
        i_reset_n = 1'b1; i_ce = 1'b0;
    endtask

    task automatic rand_words(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 10'($urandom_range(0, 1023)), 1'b0);
    endtask

    // Token stream delayed by 'off' bits, alternating t0/t1; optional idle
    // cycles before odd words and a realign on word index 'ra'.
    task automatic stream(input int off, input int n, input logic [9:0] t0,
                          input logic [9:0] t1, input bit gap, input int ra);
        bit q[$];
        logic [9:0] w, t;
        int k;
        for (int i = 0; i < off; i++) q.push_back(1'b0);
        k = 0;
        while (q.size() < n * 10) begin
            t = (k % 2 != 0) ? t1 : t0;
            for (int j = 0; j < 10; j++) q.push_back(t[j]);
            k++;
        end
        for (int i = 0; i < n; i++) begin
            for (int j = 0; j < 10; j++) w[j] = q[i * 10 + j];
            if (gap && (i % 2 != 0)) cyc(1'b0, 10'($urandom), 1'b0);
            cyc(1'b1, w, (i == ra));
        end
    endtask

    initial begin
        model_reset();
        do_reset();
        do_reset();
        chk("reset_locked", 32'(o_locked), 0);
        chk("reset_shift", 32'(o_shift), 0);

        // aligned 0x354 stream
        stream(0, 9, 10'h354, 10'h354, 1'b0, -1);
        chk("aligned_locked", 32'(o_locked), 1);
        chk("aligned_shift", 32'(o_shift), 0);
        chk("aligned_ctrl", 32'(o_ctrl), 1);
        chk("aligned_data", 32'(o_ctrl_data), 0);
        cyc(1'b0, 10'h000, 1'b0);

        // reset while locked
        do_reset();
        chk("rst_locked", 32'(o_locked), 0);
        chk("rst_shift", 32'(o_shift), 0);
        chk("rst_ce", 32'(o_ce), 0);
        chk("rst_word", 32'(o_word), 0);

        // stream offset by 3 bits: search walks 0..3 then locks
        stream(3, 64, 10'h0AB, 10'h2AB, 1'b0, -1);
        chk("delay3_locked", 32'(o_locked), 1);
        chk("delay3_shift", 32'(o_shift), 3);
        chk("delay3_word", 32'(o_word), 32'h0AB);
        chk("delay3_data", 32'(o_ctrl_data), 1);

        // random data: full rotation cycle, then onward to shift 9
        do_reset();
        rand_words(10 * DWELL);
        chk("rand_locked", 32'(o_locked), 0);
        chk("rand_shift_wrap", 32'(o_shift), 0);
        rand_words(9 * DWELL);
        chk("rand_shift9", 32'(o_shift), 9);

        // realign on the same cycle the run completes at shift 9
        stream(9, 9, 10'h354, 10'h354, 1'b0, 8);
        chk("realign_locked", 32'(o_locked), 0);
        chk("realign_shift", 32'(o_shift), 0);

        // token run with idle gaps still locks
        stream(0, 10, 10'h154, 10'h154, 1'b1, -1);
        chk("gap_locked", 32'(o_locked), 1);
        chk("gap_shift", 32'(o_shift), 0);
        chk("gap_data", 32'(o_ctrl_data), 2);

        // lock at shift 5 then time out on random data
        do_reset();
        rand_words(5 * DWELL);
        chk("tmo_pre_shift", 32'(o_shift), 5);
        stream(5, 9, 10'h354, 10'h154, 1'b0, -1);
        chk("tmo_locked", 32'(o_locked), 1);
        rand_words(TMO - 1);
        chk("tmo_still_locked", 32'(o_locked), 1);
        rand_words(1);
        chk("tmo_dropped", 32'(o_locked), 0);
        chk("tmo_shift", 32'(o_shift), 6);

        // periodic token bursts hold the lock
        do_reset();
        rand_words(5 * DWELL);
        stream(5, 9, 10'h0AB, 10'h2AB, 1'b0, -1);
        for (int r = 0; r < 3; r++) begin
            rand_words(32);
            stream(5, 9, 10'h354, 10'h0AB, 1'b0, -1);
        end
        rand_words(20);
        chk("hold_locked", 32'(o_locked), 1);
        chk("hold_shift", 32'(o_shift), 5);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
